// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D converter arbiter.
package a2d_pkg;

  typedef logic [2:0]  chnnl_t;
  typedef logic [11:0] a2d_res_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } a2d_arb_state_t;

  localparam a2d_res_t A2D_ERR_RES = 12'hFFF;

endpackage

// File: rtl/a2d_arbiter_if.sv
// Requester-side and converter-side signals of the A2D arbiter, grouped as one bundle.
interface a2d_arbiter_if
  import a2d_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] req_chnnl;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  a2d_res_t             rd_data;
  logic                 strt_cnv;
  chnnl_t               chnnl;
  logic                 cnv_cmplt;
  a2d_res_t             res;

  // Arbiter side.
  modport slave (
    input  req, req_chnnl, cnv_cmplt, res,
    output gnt, done, err, rd_data, strt_cnv, chnnl
  );

  // Requesters plus converter side.
  modport master (
    output req, req_chnnl, cnv_cmplt, res,
    input  gnt, done, err, rd_data, strt_cnv, chnnl
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping mod N.
module rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned     pos;
  logic [IdxW-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest asserted request overwrites last.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos     = (int'(ptr_i) + k) % N;
      pos_idx = IdxW'(pos);
      if (req_i[pos_idx]) begin
        idx_o = pos_idx;
      end
    end
  end

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin sharing of one A2D converter among NUM_REQ requesters, with a watchdog abort.
module a2d_arbiter
  import a2d_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic          clk,
  input logic          rst_n,
  a2d_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT);

  a2d_arb_state_t  state_q, state_d;
  logic [IdxW-1:0] win_id_q, win_id_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  chnnl_t          chnnl_q, chnnl_d;
  a2d_res_t        rd_data_q, rd_data_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            err_flag_q, err_flag_d;

  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

  rr_pick #(
    .N(NUM_REQ)
  ) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_id_q   <= '0;
      ptr_q      <= '0;
      chnnl_q    <= '0;
      rd_data_q  <= '0;
      timer_q    <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_id_q   <= win_id_d;
      ptr_q      <= ptr_d;
      chnnl_q    <= chnnl_d;
      rd_data_q  <= rd_data_d;
      timer_q    <= timer_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_id_d   = win_id_q;
    ptr_d      = ptr_q;
    chnnl_d    = chnnl_q;
    rd_data_d  = rd_data_q;
    timer_d    = timer_q;
    err_flag_d = err_flag_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_id_d = pick_idx;
          chnnl_d  = bus.req_chnnl[3*int'(pick_idx) +: 3];
          state_d  = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving in the timeout cycle still counts as a good result.
        if (bus.cnv_cmplt) begin
          rd_data_d = bus.res;
          state_d   = DONE;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          rd_data_d  = A2D_ERR_RES;
          err_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        err_flag_d = 1'b0;
        ptr_d      = IdxW'((int'(win_id_q) + 1) % NUM_REQ);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt      = '0;
    bus.done     = '0;
    bus.err      = 1'b0;
    bus.strt_cnv = (state_q == START);
    bus.chnnl    = chnnl_q;
    bus.rd_data  = rd_data_q;
    if (state_q != IDLE) begin
      bus.gnt[win_id_q] = 1'b1;
    end
    if (state_q == DONE) begin
      bus.done[win_id_q] = 1'b1;
      bus.err            = err_flag_q;
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter with a behavioural converter model and a hang-stub mode.
module tb_a2d_arbiter;

  localparam int unsigned NumReq  = 2;
  localparam int unsigned Timeout = 64;
  localparam int unsigned Lat     = 8;
  localparam int          Limit   = 300;

  logic clk;
  logic rst_n;

  a2d_arbiter_if #(.NUM_REQ(NumReq)) bus ();

  a2d_arbiter #(
    .NUM_REQ (NumReq),
    .TIMEOUT (Timeout)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  function automatic logic [11:0] model_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return 12'h0F0;
      3'd1:    return 12'h111;
      3'd2:    return 12'h2A2;
      3'd3:    return 12'h333;
      3'd4:    return 12'h444;
      3'd5:    return 12'h5B5;
      3'd6:    return 12'h666;
      default: return 12'hA5C;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Converter model: answers LAT cycles after strt_cnv unless stub_hang is set.
  logic        stub_hang;
  logic        force_cmplt;
  logic        model_cmplt;
  logic [11:0] model_res;
  logic        busy;
  int          cnt;
  logic [2:0]  lat_ch;

  assign bus.cnv_cmplt = model_cmplt | force_cmplt;
  assign bus.res       = model_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      cnt         <= 0;
      model_cmplt <= 1'b0;
      model_res   <= 12'h000;
      lat_ch      <= 3'd0;
    end else begin
      model_cmplt <= 1'b0;
      if (bus.strt_cnv) begin
        busy   <= !stub_hang;
        cnt    <= 0;
        lat_ch <= bus.chnnl;
      end else if (busy) begin
        cnt <= cnt + 1;
        if (cnt == int'(Lat) - 1) begin
          busy        <= 1'b0;
          model_cmplt <= 1'b1;
          model_res   <= model_val(lat_ch);
        end
      end
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for protocol invariants, sampled mid-cycle.
  int         strt_cyc;
  logic [2:0] strt_ch;
  int         n_gnt_bad;
  int         n_gap_bad;
  int         n_ch_bad;
  int         last_strt;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gnt != '0 && !$onehot(bus.gnt)) n_gnt_bad++;
      if (busy && bus.chnnl != lat_ch) n_ch_bad++;
      if (bus.strt_cnv) begin
        if (last_strt >= 0 && cyc - last_strt < 3) n_gap_bad++;
        last_strt = cyc;
        strt_cyc  = cyc;
        strt_ch   = bus.chnnl;
      end
    end else begin
      last_strt = -1;
    end
  end

  task automatic wait_done(output logic ok);
    int n;
    n = 0;
    while (bus.done == '0 && n < Limit) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.done != '0);
  endtask

  task automatic txn(input logic [1:0] r, input logic [2:0] c0, input logic [2:0] c1,
                     output logic ok, output logic [1:0] d, output logic [11:0] rd,
                     output logic e, output logic [2:0] ch, output int lat_s,
                     output int lat_d);
    int drive_cyc;
    @(negedge clk);
    bus.req       = r;
    bus.req_chnnl = {c1, c0};
    drive_cyc     = cyc;
    @(negedge clk);
    wait_done(ok);
    d     = bus.done;
    rd    = bus.rd_data;
    e     = bus.err;
    ch    = strt_ch;
    lat_s = strt_cyc - drive_cyc;
    lat_d = cyc - strt_cyc;
    bus.req = '0;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  ch0;
    logic [2:0]  ch1;
    logic [1:0]  exp_done;
    logic [2:0]  exp_ch;
    logic [11:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  logic        ok;
  logic [1:0]  d;
  logic [11:0] rd;
  logic        e;
  logic [2:0]  ch;
  int          lat_s;
  int          lat_d;
  logic [11:0] rd_hold;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    n_gnt_bad     = 0;
    n_gap_bad     = 0;
    n_ch_bad      = 0;
    last_strt     = -1;
    strt_cyc      = 0;
    strt_ch       = 3'd0;
    cyc           = 0;
    rst_n         = 1'b0;
    stub_hang     = 1'b0;
    force_cmplt   = 1'b0;
    bus.req       = '0;
    bus.req_chnnl = '0;

    // Pointer starts at 0; served requester drops to lowest priority.
    vecs[0] = '{2'b01, 3'd7, 3'd0, 2'b01, 3'd7, 12'hA5C};
    vecs[1] = '{2'b11, 3'd1, 3'd4, 2'b10, 3'd4, 12'h444};
    vecs[2] = '{2'b11, 3'd1, 3'd4, 2'b01, 3'd1, 12'h111};
    vecs[3] = '{2'b11, 3'd1, 3'd4, 2'b10, 3'd4, 12'h444};
    vecs[4] = '{2'b10, 3'd0, 3'd2, 2'b10, 3'd2, 12'h2A2};
    vecs[5] = '{2'b10, 3'd0, 3'd5, 2'b10, 3'd5, 12'h5B5};
    vecs[6] = '{2'b01, 3'd3, 3'd0, 2'b01, 3'd3, 12'h333};
    vecs[7] = '{2'b01, 3'd0, 3'd0, 2'b01, 3'd0, 12'h0F0};
    vecs[8] = '{2'b11, 3'd6, 3'd7, 2'b10, 3'd7, 12'hA5C};

    #12;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_strt", 32'(bus.strt_cnv), 32'h0);
    check("rst_chnnl", 32'(bus.chnnl), 32'h0);
    check("rst_rd", 32'(bus.rd_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].req, vecs[i].ch0, vecs[i].ch1, ok, d, rd, e, ch, lat_s, lat_d);
      check($sformatf("v%0d_ok", i), 32'(ok), 32'h1);
      check($sformatf("v%0d_done", i), 32'(d), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_chnnl", i), 32'(ch), 32'(vecs[i].exp_ch));
      check($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_err", i), 32'(e), 32'h0);
      check($sformatf("v%0d_lat_strt", i), 32'(lat_s), 32'd1);
      check($sformatf("v%0d_lat_done", i), 32'(lat_d), 32'(Lat + 2));
    end

    // Completion strobe with nobody waiting must be ignored.
    @(negedge clk);
    rd_hold     = bus.rd_data;
    force_cmplt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle_cmplt_done%0d", i), 32'(bus.done), 32'h0);
      check($sformatf("idle_cmplt_gnt%0d", i), 32'(bus.gnt), 32'h0);
      check($sformatf("idle_cmplt_strt%0d", i), 32'(bus.strt_cnv), 32'h0);
    end
    force_cmplt = 1'b0;
    @(negedge clk);
    check("idle_cmplt_rd", 32'(bus.rd_data), 32'(rd_hold));

    // Converter never answers: watchdog abort.
    stub_hang = 1'b1;
    txn(2'b01, 3'd3, 3'd0, ok, d, rd, e, ch, lat_s, lat_d);
    check("to_ok", 32'(ok), 32'h1);
    check("to_done", 32'(d), 32'h1);
    check("to_err", 32'(e), 32'h1);
    check("to_rd", 32'(rd), 32'hFFF);
    check("to_lat", 32'(lat_d), 32'(Timeout + 1));
    @(negedge clk);
    check("to_err_pulse", 32'(bus.err), 32'h0);
    check("to_rd_hold", 32'(bus.rd_data), 32'hFFF);

    // Reset in the middle of a hung conversion; pointer was 1 beforehand.
    @(negedge clk);
    bus.req       = 2'b10;
    bus.req_chnnl = {3'd6, 3'd2};
    repeat (6) @(negedge clk);
    check("pre_rst_gnt", 32'(bus.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    check("mid_rst_err", 32'(bus.err), 32'h0);
    check("mid_rst_strt", 32'(bus.strt_cnv), 32'h0);
    check("mid_rst_chnnl", 32'(bus.chnnl), 32'h0);
    check("mid_rst_rd", 32'(bus.rd_data), 32'h0);
    bus.req   = '0;
    stub_hang = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesting continuously from reset: strict alternation starting with 0.
    bus.req       = 2'b11;
    bus.req_chnnl = {3'd4, 3'd1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wait_done(ok);
      check($sformatf("rr%0d_ok", i), 32'(ok), 32'h1);
      check($sformatf("rr%0d_done", i), 32'(bus.done), (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d_rd", i), 32'(bus.rd_data), (i % 2 == 0) ? 32'h111 : 32'h444);
      check($sformatf("rr%0d_err", i), 32'(bus.err), 32'h0);
    end
    @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);

    check("gnt_onehot", 32'(n_gnt_bad), 32'h0);
    check("strt_gap", 32'(n_gap_bad), 32'h0);
    check("chnnl_stable", 32'(n_ch_bad), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
